// File: rtl/fetch_unit_pkg.sv
// Shared types and default sizes for the instruction fetch front end.
// Defaults: 4-entry queue, 8-word instruction memory, 32-bit instructions.
package fetch_unit_pkg;

    localparam int FQ_DEPTH_DEF      = 4;
    localparam int FQ_DEPTH_LOG      = $clog2(FQ_DEPTH_DEF);
    localparam int MEMI_SIZE_LOG_DEF = 3;
    localparam int INST_LEN_DEF      = 32;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_STALL = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {inst, pc} entries; flush has priority over push/pop.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    input  logic                       flush,
    output logic [W-1:0]               head_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_dat  = r_mem[r_head];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Pointers are exactly PW bits wide, so increments wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_tail] <= push_dat;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_do_pop) r_head <= r_head + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// In-order fetch: drives req_addr=pc, queues {resp_data, pc}, presents head to decode.
// Latency: instruction at pc in cycle N appears on out_* in cycle N+1; redirect-to-output is 2 cycles.
// Backpressure: out_ready low fills the queue, then fetch stalls with pc held; redirect flushes.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int FQ_DEPTH      = FQ_DEPTH_DEF,
    parameter int MEMI_SIZE_LOG = MEMI_SIZE_LOG_DEF,
    parameter int INST_LEN      = INST_LEN_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    output logic [MEMI_SIZE_LOG-1:0] req_addr,
    input  logic [INST_LEN-1:0]      resp_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INST_LEN-1:0]      out_inst,
    output logic [MEMI_SIZE_LOG-1:0] out_pc,
    input  logic                     redirect_valid,
    input  logic [MEMI_SIZE_LOG-1:0] redirect_pc
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam int EW = INST_LEN + MEMI_SIZE_LOG;

    fetch_state_t             r_state;
    fetch_state_t             w_state_nxt;
    logic [MEMI_SIZE_LOG-1:0] r_pc;
    logic [EW-1:0]            w_q_head;
    logic                     w_q_full;
    logic                     w_q_empty;
    logic [CW-1:0]            w_q_count;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_full_nxt;

    assign req_addr  = r_pc;
    assign out_valid = ~w_q_empty;
    assign out_inst  = out_valid ? w_q_head[EW-1:MEMI_SIZE_LOG] : '0;
    assign out_pc    = out_valid ? w_q_head[MEMI_SIZE_LOG-1:0]  : '0;
    assign w_pop     = out_valid & out_ready;
    assign w_push    = (r_state == FETCH_RUN) & ~redirect_valid & (~w_q_full | w_pop);

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .W     (EW)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .push_dat ({resp_data, r_pc}),
        .pop      (w_pop & ~redirect_valid),
        .flush    (redirect_valid),
        .head_dat (w_q_head),
        .full     (w_q_full),
        .empty    (w_q_empty),
        .count    (w_q_count)
    );

    // Queue will be full after this edge and nothing is leaving it.
    assign w_full_nxt = ~w_pop & (w_q_full | (w_push & (w_q_count == CW'(FQ_DEPTH - 1))));

    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = fetch_en ? FETCH_RUN : FETCH_IDLE;
        end else begin
            unique case (r_state)
                FETCH_IDLE: begin
                    if (fetch_en) w_state_nxt = FETCH_RUN;
                end
                FETCH_RUN: begin
                    if (!fetch_en)      w_state_nxt = FETCH_IDLE;
                    else if (w_full_nxt) w_state_nxt = FETCH_STALL;
                end
                FETCH_STALL: begin
                    if (!fetch_en) w_state_nxt = FETCH_IDLE;
                    else if (w_pop) w_state_nxt = FETCH_RUN;
                end
                default: w_state_nxt = FETCH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FETCH_IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_valid) r_pc <= redirect_pc;
            else if (w_push)    r_pc <= r_pc + 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table for startup/redirect/wrap, scoreboard sequences for
// stall, fetch_en drain/resume and asynchronous reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [2:0]  req_addr;
    logic [31:0] resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [2:0]  out_pc;
    logic        redirect_valid;
    logic [2:0]  redirect_pc;

    logic [31:0] mem [8];
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [2:0]  pc;
        logic [31:0] inst;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic       en;
        logic       rdy;
        logic       rv;
        logic [2:0] rpc;
        logic       ev;
        logic [2:0] epc;
        logic [2:0] ereq;
    } vec_t;
    vec_t vt[11];

    always #5 clk = ~clk;

    assign resp_data = mem[req_addr];

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .req_addr       (req_addr),
        .resp_data      (resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        fetch_en = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 3'd0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic expect_range(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [2:0] p;
            p = 3'((start + i) % 8);
            sb.push_back({p, mem[p]});
        end
    endtask

    // Compares every accepted head against the scoreboard; caller sits at posedge+1.
    task automatic drain_check(input string name, input int n, input int budget);
        int got = 0;
        int cyc = 0;
        exp_t e;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk({name, "_extra"}, 32'(out_pc), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk({name, "_pc"}, 32'(out_pc), 32'(e.pc));
                    chk({name, "_inst"}, out_inst, e.inst);
                end
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (got < n) begin
            n_checks++;
            $display("FAIL %s_timeout: got %0d pops expected %0d", name, got, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 32'hA000_0000 + 32'(i) * 32'h0101_0111;

        //         en    rdy   rv    rpc   ev    epc   ereq
        vt[0]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd0, 3'd1};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd1, 3'd2};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 3'd3};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 3'd4};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 3'd6, 1'b1, 3'd2, 3'd5};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 3'd6};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd6, 3'd7};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd7, 3'd0};
        vt[10] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd0, 3'd1};

        rst = 1'b0;
        fetch_en = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 3'd0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_req", 32'(req_addr), 32'd0);
        chk("rst_pc", 32'(out_pc), 32'd0);
        chk("rst_inst", out_inst, 32'd0);

        // Startup latency, redirect coincident with a pop, pc wrap past 7.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            fetch_en       = vt[i].en;
            out_ready      = vt[i].rdy;
            redirect_valid = vt[i].rv;
            redirect_pc    = vt[i].rpc;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].ev));
            chk($sformatf("vec%0d_pc", i), 32'(out_pc), 32'(vt[i].epc));
            chk($sformatf("vec%0d_inst", i), out_inst, vt[i].ev ? mem[vt[i].epc] : 32'd0);
            chk($sformatf("vec%0d_req", i), 32'(req_addr), 32'(vt[i].ereq));
            @(posedge clk);
            #1;
        end
        redirect_valid = 1'b0;

        // Backpressure: queue fills with W0..W3, pc parks at 4, then drains in order.
        do_reset();
        fetch_en = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_pc", 32'(out_pc), 32'd0);
        chk("stall_inst", out_inst, mem[0]);
        chk("stall_req", 32'(req_addr), 32'd4);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        expect_range(0, 8);
        drain_check("stall_drain", 8, 30);

        // fetch_en dropped with two entries queued: both drain, pc frozen, then resume.
        do_reset();
        fetch_en = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        fetch_en = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("dis_req", 32'(req_addr), 32'd2);
        chk("dis_valid", 32'(out_valid), 32'd1);
        chk("dis_pc", 32'(out_pc), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        expect_range(0, 2);
        drain_check("dis_drain", 2, 10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("dis_idle%0d_valid", i), 32'(out_valid), 32'd0);
            chk($sformatf("dis_idle%0d_req", i), 32'(req_addr), 32'd2);
            @(posedge clk);
            #1;
        end
        fetch_en = 1'b1;
        expect_range(2, 2);
        drain_check("resume", 2, 10);

        // Asynchronous reset mid-stream, observed before the next edge.
        do_reset();
        fetch_en = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_req", 32'(req_addr), 32'd0);
        chk("arst_pc", 32'(out_pc), 32'd0);
        chk("arst_inst", out_inst, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        expect_range(0, 3);
        drain_check("arst_restart", 3, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
